mnist_roi_crop: RTL and testbench

Front-end stage of the MNIST path, upstream of `mnist_256to1pix`. It receives the raw RGB565 camera stream and tracks the frame geometry with `cmos_vsync`/`cmos_href`. It crops a fixed 448×448 window, converts each pixel to inverted 8-bit gray (white digit on black), and emits one `mnist_data_valid` pulse per window pixel. After the last window pixel it pulses `mnist_start`, so the 16×16-to-1 downsampler sees exactly 200704 samples per frame followed by its start strobe.

---
 rtl/mnist_pkg.sv | 21 ++
 rtl/mnist_roi_crop_if.sv | 24 ++
 rtl/mnist_rgb565_to_gray.sv | 84 ++++++++
 rtl/mnist_roi_crop.sv | 158 +++++++++++++++
 tb/tb_mnist_roi_crop.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST front-end and downsampler:
// the capture FSM state encoding, the luma weights and the default
// window geometry.
package mnist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } roi_state_e;

  // BT.601-style luma weights scaled by 256; they sum to 256
  localparam logic [15:0] COEF_R = 16'd77;
  localparam logic [15:0] COEF_G = 16'd150;
  localparam logic [15:0] COEF_B = 16'd29;

  localparam int ROI_SIZE_DEF = 448;
  localparam int MNIST_DIM    = 28;

endpackage

// File: rtl/mnist_roi_crop_if.sv
// Camera-in / MNIST-sample-out bundle for mnist_roi_crop.
// master: the camera side (drives the cmos_* stream, consumes samples).
// slave:  the crop stage itself.
interface mnist_roi_crop_if;

  logic        cmos_vsync;
  logic        cmos_href;
  logic        cmos_data_valid;
  logic [15:0] cmos_data;
  logic        mnist_data_valid;
  logic [7:0]  mnist_data;
  logic        mnist_start;

  modport master (
    output cmos_vsync, cmos_href, cmos_data_valid, cmos_data,
    input  mnist_data_valid, mnist_data, mnist_start
  );

  modport slave (
    input  cmos_vsync, cmos_href, cmos_data_valid, cmos_data,
    output mnist_data_valid, mnist_data, mnist_start
  );

endinterface

// File: rtl/mnist_rgb565_to_gray.sv
// Two-stage RGB565 -> inverted 8-bit gray pipeline.
// Stage 1 expands the channels to 8 bits and registers the three
// weighted products; stage 2 sums, keeps the top byte and inverts.
// With MNIST_ROI_BINARIZE_EN defined, stage 2 instead thresholds the
// luma against THRESH (dark pixel -> 255, light pixel -> 0).
module mnist_rgb565_to_gray
  import mnist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [15:0] data_i,
  output logic        valid_o,
  output logic [7:0]  data_o
);

`ifdef MNIST_ROI_BINARIZE_EN
  parameter int THRESH = 128;
  localparam logic [8:0] THRESH9 = 9'(THRESH);
`endif

  logic [7:0]  r8, g8, b8;
  logic [15:0] pr_d, pg_d, pb_d;
  logic [15:0] pr_q, pg_q, pb_q;
  logic        v1_q;
  logic [15:0] sum;
  logic [7:0]  y;
  logic [7:0]  data_d;
  logic [7:0]  data_q;
  logic        v2_q;

  // Replicate the MSBs into the LSBs so full-scale 5/6-bit maps to 255
  always_comb begin
    r8   = {data_i[15:11], data_i[15:13]};
    g8   = {data_i[10:5],  data_i[10:9]};
    b8   = {data_i[4:0],   data_i[4:2]};
    pr_d = COEF_R * {8'h00, r8};
    pg_d = COEF_G * {8'h00, g8};
    pb_d = COEF_B * {8'h00, b8};
  end

  // Stage 1: weighted channel products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_q <= '0;
      pg_q <= '0;
      pb_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        pr_q <= pr_d;
        pg_q <= pg_d;
        pb_q <= pb_d;
      end
    end
  end

  // Weights sum to 256, so the 16-bit sum peaks at 65280 and cannot wrap
  always_comb begin
    sum = pr_q + pg_q + pb_q;
    y   = sum[15:8];
`ifdef MNIST_ROI_BINARIZE_EN
    data_d = ({1'b0, y} < THRESH9) ? 8'd255 : 8'd0;
`else
    data_d = 8'd255 - y;
`endif
  end

  // Stage 2: luma, inverted (or binarized) sample out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) data_q <= data_d;
    end
  end

  assign valid_o = v2_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mnist_roi_crop.sv
// MNIST front-end: tracks camera frame geometry, crops a square window,
// converts it to inverted gray and strobes mnist_start after the last
// window sample. Optional macro: MNIST_ROI_BINARIZE_EN (binary output).
//
// state      | meaning
// -----------+----------------------------------------------------
// ST_IDLE    | not armed; waits for vsync rise with roi_en=1
// ST_ARMED   | frame started, waiting for the first window pixel
// ST_CAPTURE | inside the window, counting accepted pixels
// ST_DONE    | full window delivered; waits for the next vsync rise
module mnist_roi_crop
  import mnist_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int ROI_X0   = 96,
  parameter int ROI_Y0   = 16,
  parameter int ROI_SIZE = ROI_SIZE_DEF,
  parameter int THRESH   = 128
) (
  input  logic            cmos_pclk,
  input  logic            rst_n,
  mnist_roi_crop_if.slave bus,
  input  logic            roi_en,
  output logic            frame_err
);

  localparam logic [10:0] X_LO = 11'(ROI_X0);
  localparam logic [10:0] X_HI = 11'(ROI_X0 + ROI_SIZE);
  localparam logic [10:0] Y_LO = 11'(ROI_Y0);
  localparam logic [10:0] Y_HI = 11'(ROI_Y0 + ROI_SIZE);
  localparam logic [17:0] LAST_PIX = 18'(ROI_SIZE * ROI_SIZE - 1);

  // A configuration whose window cannot fit the frame would never finish;
  // keep the block inert instead of emitting a partial window.
  localparam bit CFG_OK = (ROI_SIZE > 0) && (ROI_SIZE % 16 == 0) &&
                          (ROI_X0 >= 0) && (ROI_Y0 >= 0) &&
                          (ROI_X0 + ROI_SIZE <= IMG_W) &&
                          (ROI_Y0 + ROI_SIZE <= IMG_H) &&
                          (IMG_W <= 2047) && (IMG_H <= 2047) &&
                          (THRESH >= 0) && (THRESH <= 256);

  roi_state_e  state_q, state_d;
  logic        vs_q, hr_q;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [17:0] pix_cnt_q, pix_cnt_d;
  logic [2:0]  last_sr_q;
  logic        frame_err_q;
  logic        vs_rise, hr_fall, pix_stb, pix_in_win;
  logic        accept, last_pix, abort;

  assign vs_rise    = bus.cmos_vsync & ~vs_q;
  assign hr_fall    = ~bus.cmos_href & hr_q;
  assign pix_stb    = bus.cmos_data_valid & bus.cmos_href;
  assign pix_in_win = CFG_OK && pix_stb &&
                      (h_cnt_q >= X_LO) && (h_cnt_q < X_HI) &&
                      (v_cnt_q >= Y_LO) && (v_cnt_q < Y_HI);

  // Capture FSM: arm on vsync, count window pixels, abort on early vsync
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_pix = 1'b0;
    abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vs_rise && roi_en) state_d = ST_ARMED;
      end
      ST_ARMED, ST_CAPTURE: begin
        if (vs_rise) begin
          abort   = 1'b1;
          state_d = roi_en ? ST_ARMED : ST_IDLE;
        end else if (pix_in_win) begin
          accept = 1'b1;
          if (pix_cnt_q == LAST_PIX) begin
            last_pix = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_DONE: begin
        if (vs_rise) state_d = roi_en ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Geometry counters: column saturates, line steps on href fall
  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    pix_cnt_d = pix_cnt_q;
    if (vs_rise) begin
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      pix_cnt_d = '0;
    end else begin
      if (hr_fall) begin
        h_cnt_d = '0;
        v_cnt_d = v_cnt_q + 11'd1;
      end else if (pix_stb && h_cnt_q != 11'h7FF) begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
      if (accept) pix_cnt_d = pix_cnt_q + 18'd1;
    end
  end

  // Edge-detect copies and geometry counters
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      hr_q      <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pix_cnt_q <= '0;
    end else begin
      vs_q      <= bus.cmos_vsync;
      hr_q      <= bus.cmos_href;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  // FSM state plus status strobes; start trails the last pixel by the
  // pipeline depth plus one so it lands right after its output sample
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_sr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_sr_q   <= {last_sr_q[1:0], last_pix};
      frame_err_q <= abort;
    end
  end

  mnist_rgb565_to_gray
`ifdef MNIST_ROI_BINARIZE_EN
    #(.THRESH(THRESH))
`endif
  u_gray (
    .clk     (cmos_pclk),
    .rst_n   (rst_n),
    .valid_i (accept),
    .data_i  (bus.cmos_data),
    .valid_o (bus.mnist_data_valid),
    .data_o  (bus.mnist_data)
  );

  assign bus.mnist_start = last_sr_q[2];
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_mnist_roi_crop.sv
// Scoreboard bench for mnist_roi_crop on a reduced 64x48 frame with a
// 32x32 window at (8,4). The stimulus side predicts every output sample,
// start strobe and frame error (value and cycle) into queues; a monitor
// on the falling edge pops and compares whatever the DUT presents.
module tb_mnist_roi_crop;
  import mnist_pkg::*;

  localparam int IMG_W = 64;
  localparam int IMG_H = 48;
  localparam int X0    = 8;
  localparam int Y0    = 4;
  localparam int RS    = 32;
  localparam int THR   = 128;
  localparam int NPIX  = RS * RS;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic roi_en = 1'b0;
  logic frame_err;

  mnist_roi_crop_if bus();

  mnist_roi_crop #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ROI_X0(X0), .ROI_Y0(Y0),
    .ROI_SIZE(RS), .THRESH(THR)
  ) dut (
    .cmos_pclk (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .roi_en    (roi_en),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    int unsigned at;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned start_q[$];
  int unsigned err_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          cap_active = 0;
  int          cap_cnt = 0;
  exp_t        mon_e;
  int unsigned mon_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference luma from the channel-expansion and weighting rules
  function automatic logic [7:0] ref_gray(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8, y;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    y  = (77 * r8 + 150 * g8 + 29 * b8) / 256;
`ifdef MNIST_ROI_BINARIZE_EN
    return (y < THR) ? 8'd255 : 8'd0;
`else
    return 8'(255 - y);
`endif
  endfunction

  function automatic logic [15:0] pick(input int mode);
    case (mode)
      1: return 16'hFFFF;
      2: return 16'h0000;
      3: return 16'hF800;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: every DUT strobe must match the head of its queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mnist_data_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("pix_data", {24'd0, bus.mnist_data}, {24'd0, mon_e.data});
          chk("pix_cycle", cyc, mon_e.at);
        end
      end
      if (bus.mnist_start) begin
        if (start_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
        else begin
          mon_t = start_q.pop_front();
          chk("start_cycle", cyc, mon_t);
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) chk("unexpected_frame_err", 32'd1, 32'd0);
        else begin
          mon_t = err_q.pop_front();
          chk("frame_err_cycle", cyc, mon_t);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: vsync pulse, then `lines` lines of IMG_W pixels.
  // rst_line / flip_line < 0 disable the mid-frame reset / roi_en toggle.
  task automatic send_frame(input bit arm, input int lines, input int mode,
                            input bit gaps, input int tail_last,
                            input int rst_line, input int flip_line);
    logic [15:0] px;
    roi_en = arm;
    tick();
    bus.cmos_vsync      = 1'b1;
    bus.cmos_href       = 1'b0;
    bus.cmos_data_valid = 1'b0;
    if (cap_active) err_q.push_back(cyc + 1);
    cap_active = arm;
    cap_cnt    = 0;
    repeat (2) tick();
    tick();
    bus.cmos_vsync = 1'b0;
    repeat (2) tick();
    for (int y = 0; y < lines; y++) begin
      if (y == rst_line) begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cap_active = 0;
      end
      if (y == flip_line) roi_en = ~roi_en;
      tick();
      bus.cmos_href       = 1'b1;
      bus.cmos_data_valid = 1'b0;
      for (int x = 0; x < IMG_W; x++) begin
        if (gaps && $urandom_range(3) == 0) begin
          tick();
          bus.cmos_data_valid = 1'b0;
        end
        tick();
        px = pick(mode);
        bus.cmos_data_valid = 1'b1;
        bus.cmos_data       = px;
        if (cap_active && x >= X0 && x < X0 + RS && y >= Y0 && y < Y0 + RS) begin
          exp_q.push_back('{ref_gray(px), cyc + 2});
          cap_cnt++;
          if (cap_cnt == NPIX) begin
            start_q.push_back(cyc + 3);
            cap_active = 0;
          end
        end
      end
      tick();
      bus.cmos_data_valid = 1'b0;
      bus.cmos_href       = 1'b0;
      repeat ((y == lines - 1) ? tail_last : 2) tick();
    end
  endtask

  initial begin
    bus.cmos_vsync      = 1'b0;
    bus.cmos_href       = 1'b0;
    bus.cmos_data_valid = 1'b0;
    bus.cmos_data       = 16'h0000;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.mnist_data_valid}, 32'd0);
    chk("rst_data", {24'd0, bus.mnist_data}, 32'd0);
    chk("rst_start", {31'd0, bus.mnist_start}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;

    // Full frames: white -> 0, black -> 255, pure red -> 179
    send_frame(1, IMG_H, 1, 0, 2, -1, -1);
    send_frame(1, IMG_H, 2, 1, 2, -1, -1);
    send_frame(1, IMG_H, 3, 1, 2, -1, -1);
    // Not armed at vsync; raising roi_en mid-frame must not start capture
    send_frame(0, IMG_H, 0, 1, 2, -1, 2);
    // Cut short 10 lines into the window: abort at the next vsync
    send_frame(1, Y0 + 10, 0, 1, 0, -1, -1);
    // Completes normally after the abort
    send_frame(1, IMG_H, 0, 0, 2, -1, -1);
    // Async reset inside the window: nothing more this frame
    send_frame(1, IMG_H, 0, 1, 2, Y0 + 6, -1);
    send_frame(1, IMG_H, 0, 1, 2, -1, -1);
    // roi_en dropped mid-frame has no effect on the running capture
    send_frame(1, IMG_H, 0, 1, 2, -1, Y0 + 3);

    repeat (10) tick();
    chk("pix_queue_drained", exp_q.size(), 32'd0);
    chk("start_queue_drained", start_q.size(), 32'd0);
    chk("err_queue_drained", err_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
